// File: rtl/mul_issue_arbiter.sv
// rtl/mul_issue_arbiter.sv - round-robin issue arbiter sharing one 3-stage multiplier between two pipes
// Shadows multiplier stages 2 and 3 with valid bits and {port, op, tag}, and returns the tagged result half.
module mul_issue_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [1:0]       req0_op_i,
   input  logic [31:0]      req0_x_i,
   input  logic [31:0]      req0_y_i,
   input  logic [TAG_W-1:0] req0_tag_i,
   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [1:0]       req1_op_i,
   input  logic [31:0]      req1_x_i,
   input  logic [31:0]      req1_y_i,
   input  logic [TAG_W-1:0] req1_tag_i,
   input  logic             flush_i,
   output logic             mul_signed_o,
   output logic [31:0]      mul_x_o,
   output logic [31:0]      mul_y_o,
   output logic [1:0]       mul_stall_o,
   input  logic [63:0]      mul_res_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_port_o,
   output logic [TAG_W-1:0] resp_tag_o,
   output logic [31:0]      resp_data_o
);
   localparam logic [1:0] OP_MULH  = 2'b01;
   localparam logic [1:0] OP_MULHU = 2'b10;

   typedef struct packed {
      logic             port;
      logic [1:0]       op;
      logic [TAG_W-1:0] tag;
   } meta_t;

   logic  v2, v3, prio;
   meta_t meta2, meta3, meta_in;
   logic  stall2, stall3, can_accept, grant0, grant1;
   logic  [1:0] op_sel;

   // Flush releases both stalls so the pipeline drains freely while the valids are cleared.
   assign stall3      = v3 & ~resp_ready_i & ~flush_i;
   assign stall2      = stall3 & v2;
   assign mul_stall_o = {stall3, stall2};

   assign can_accept   = ~stall2 & ~flush_i;
   assign grant0       = req0_valid_i & (~req1_valid_i | ~prio) & can_accept;
   assign grant1       = req1_valid_i & (~req0_valid_i | prio) & can_accept;
   assign req0_ready_o = grant0;
   assign req1_ready_o = grant1;

   assign op_sel       = grant1 ? req1_op_i : req0_op_i;
   assign mul_x_o      = grant1 ? req1_x_i : req0_x_i;
   assign mul_y_o      = grant1 ? req1_y_i : req0_y_i;
   assign mul_signed_o = (op_sel != OP_MULHU);
   assign meta_in      = '{port: grant1, op: op_sel, tag: (grant1 ? req1_tag_i : req0_tag_i)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         v3    <= 1'b0;
         prio  <= 1'b0;
         meta2 <= '0;
         meta3 <= '0;
      end else begin
         if (grant0)      prio <= 1'b1;
         else if (grant1) prio <= 1'b0;
         if (!stall2) begin
            v2    <= grant0 | grant1;
            meta2 <= meta_in;
         end
         if (!stall3) begin
            v3    <= v2;
            meta3 <= meta2;
         end
         if (flush_i) begin
            v2 <= 1'b0;
            v3 <= 1'b0;
         end
      end
   end

   assign resp_valid_o = v3 & ~flush_i;
   assign resp_port_o  = meta3.port;
   assign resp_tag_o   = meta3.tag;
   assign resp_data_o  = (meta3.op == OP_MULH || meta3.op == OP_MULHU) ? mul_res_i[63:32] : mul_res_i[31:0];
endmodule

// File: tb/tb_mul_issue_arbiter.sv
// tb/tb_mul_issue_arbiter.sv - scoreboard bench for mul_issue_arbiter with a behavioural 3-stage multiplier
module tb_mul_issue_arbiter;
   localparam int TAG_W = 4;
   localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHU = 2'b10, RSV = 2'b11;

   typedef struct packed {
      logic [1:0]       op;
      logic [31:0]      x;
      logic [31:0]      y;
      logic [TAG_W-1:0] tag;
      logic [31:0]      e;
   } vec_t;

   typedef struct packed {
      logic             port;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0] req0_op, req1_op;
   logic [31:0] req0_x, req0_y, req1_x, req1_y;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic flush, mul_signed;
   logic [31:0] mul_x, mul_y;
   logic [1:0] mul_stall;
   logic [63:0] mul_res;
   logic resp_valid, resp_ready, resp_port;
   logic [TAG_W-1:0] resp_tag;
   logic [31:0] resp_data;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   logic [31:0] exp_d0, exp_d1;
   logic hold_prev = 1'b0;
   exp_t prev_resp;

   logic [31:0] s2_x = '0, s2_y = '0;
   logic s2_sg = 1'b0;
   logic [63:0] s3_p = '0;

   mul_issue_arbiter #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
      .req0_x_i(req0_x), .req0_y_i(req0_y), .req0_tag_i(req0_tag),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
      .req1_x_i(req1_x), .req1_y_i(req1_y), .req1_tag_i(req1_tag),
      .flush_i(flush), .mul_signed_o(mul_signed), .mul_x_o(mul_x), .mul_y_o(mul_y),
      .mul_stall_o(mul_stall), .mul_res_i(mul_res),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_port_o(resp_port),
      .resp_tag_o(resp_tag), .resp_data_o(resp_data)
   );

   always #5 clk = ~clk;

   // Multiplier: operands registered into stage 2, product into stage 3, result combinational off stage 3.
   always @(posedge clk) begin
      if (!mul_stall[0]) begin
         s2_x  <= mul_x;
         s2_y  <= mul_y;
         s2_sg <= mul_signed;
      end
      if (!mul_stall[1])
         s3_p <= s2_sg ? ({{32{s2_x[31]}}, s2_x} * {{32{s2_y[31]}}, s2_y})
                       : ({32'b0, s2_x} * {32'b0, s2_y});
   end
   assign mul_res = s3_p;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue tracker: pushes the expected response on every request handshake.
   always @(negedge clk) begin
      if (!rst_n || flush) sb.delete();
      else begin
         if (req0_valid && req0_ready) sb.push_back({1'b0, req0_tag, exp_d0});
         if (req1_valid && req1_ready) sb.push_back({1'b1, req1_tag, exp_d1});
      end
   end

   // Response monitor: in-order compare on handshake, plus stability while back-pressured.
   always @(negedge clk) begin
      exp_t got, e;
      got = {resp_port, resp_tag, resp_data};
      if (hold_prev && rst_n && !flush) chk("resp_hold", {resp_valid, got}, {1'b1, prev_resp});
      if (rst_n && resp_valid && resp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got port=%0d tag=%0h data=%0h expected no response", resp_port, resp_tag, resp_data);
         end else begin
            e = sb.pop_front();
            chk("resp", got, e);
         end
      end
      hold_prev = rst_n && resp_valid && !resp_ready && !flush;
      prev_resp = got;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input int p, input vec_t t);
      if (p == 0) begin
         req0_valid = 1'b1; req0_op = t.op; req0_x = t.x; req0_y = t.y; req0_tag = t.tag; exp_d0 = t.e;
      end else begin
         req1_valid = 1'b1; req1_op = t.op; req1_x = t.x; req1_y = t.y; req1_tag = t.tag; exp_d1 = t.e;
      end
   endtask

   task automatic idle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      chk("drain_pending", sb.size(), 0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v0[4], v1[4], bp[3];
      int i0, i1, bi;
      logic g0, g1;

      v0[0] = {MUL,   32'd7,         32'd6,         4'd1,  32'h0000002A};
      v0[1] = {MULH,  32'h80000000,  32'd2,         4'd2,  32'hFFFFFFFF};
      v0[2] = {MULHU, 32'h80000000,  32'd2,         4'd3,  32'h00000001};
      v0[3] = {MUL,   32'd5,         32'd5,         4'd15, 32'd25};
      v1[0] = {MUL,   32'hFFFFFFFF,  32'hFFFFFFFF,  4'd9,  32'h00000001};
      v1[1] = {MULH,  32'hFFFFFFFF,  32'hFFFFFFFF,  4'd10, 32'h00000000};
      v1[2] = {MULHU, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'd11, 32'hFFFFFFFE};
      v1[3] = {MUL,   32'd3,         32'd3,         4'd14, 32'd9};
      bp[0] = {RSV,   32'h00010001,  32'h00010001,  4'd1,  32'h00020001};
      bp[1] = {MUL,   32'h12345678,  32'h00000010,  4'd2,  32'h23456780};
      bp[2] = {MULHU, 32'h12345678,  32'h00000010,  4'd3,  32'h00000001};

      rst_n = 1'b0; resp_ready = 1'b1; flush = 1'b0;
      req0_op = '0; req0_x = '0; req0_y = '0; req0_tag = '0; exp_d0 = '0;
      req1_op = '0; req1_x = '0; req1_y = '0; req1_tag = '0; exp_d1 = '0;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_stall", mul_stall, 2'b00);
      chk("rst_port_tag", {resp_port, resp_tag}, 0);
      rst_n = 1'b1;
      tick();

      // Round robin with both pipes requesting every cycle.
      i0 = 0; i1 = 0;
      for (int c = 0; c < 6; c++) begin
         drv(0, v0[i0]);
         drv(1, v1[i1]);
         @(negedge clk);
         chk("rr_grant0", req0_ready, (c % 2 == 0));
         chk("rr_grant1", req1_ready, (c % 2 == 1));
         g0 = req0_ready; g1 = req1_ready;
         tick();
         if (g0) i0++;
         if (g1) i1++;
      end
      idle();
      wait_drain();

      // Latency and the three result selections.
      drv(0, {MULHU, 32'd3, 32'hFFFFFFFF, 4'd5, 32'h00000002});
      @(negedge clk);
      chk("lat_ready", req0_ready, 1);
      tick();
      idle();
      @(negedge clk);
      chk("lat_valid_n1", resp_valid, 0);
      tick();
      @(negedge clk);
      chk("lat_valid_n2", resp_valid, 1);
      tick();
      drv(0, {MULH, 32'd3, 32'hFFFFFFFF, 4'd6, 32'hFFFFFFFF});
      tick();
      drv(0, {MUL, 32'd3, 32'hFFFFFFFF, 4'd7, 32'hFFFFFFFD});
      tick();
      idle();
      wait_drain();

      // Back-pressure: two accepted, then full stall.
      resp_ready = 1'b0;
      bi = 0;
      for (int c = 0; c < 4; c++) begin
         drv(0, bp[bi]);
         @(negedge clk);
         chk("bp_ready0", req0_ready, (c < 2));
         chk("bp_stall", mul_stall, (c < 2) ? 2'b00 : 2'b11);
         g0 = req0_ready;
         tick();
         if (g0) bi++;
      end
      resp_ready = 1'b1;
      drv(0, bp[bi]);
      @(negedge clk);
      chk("bp_resume_ready0", req0_ready, 1);
      tick();
      idle();
      wait_drain();

      // Bubble squeeze.
      drv(1, {MULH, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'd12, 32'h3FFFFFFF});
      @(negedge clk);
      chk("bub_ready1", req1_ready, 1);
      tick();
      idle();
      tick();
      resp_ready = 1'b0;
      drv(0, {MUL, 32'd100, 32'd100, 4'd4, 32'd10000});
      @(negedge clk);
      chk("bub_ready0", req0_ready, 1);
      chk("bub_stall", mul_stall, 2'b10);
      tick();
      idle();
      @(negedge clk);
      chk("bub_stall_full", mul_stall, 2'b11);
      tick();
      resp_ready = 1'b1;
      wait_drain();

      // Flush with two in flight and pipe 1 waiting.
      drv(0, {MUL, 32'd2, 32'd3, 4'd6, 32'd6});
      tick();
      drv(0, {MULHU, 32'hFFFFFFFF, 32'd2, 4'd7, 32'd1});
      tick();
      idle();
      drv(1, {MUL, 32'h1234, 32'h10, 4'd8, 32'h12340});
      flush = 1'b1;
      @(negedge clk);
      chk("fl_ready0", req0_ready, 0);
      chk("fl_ready1", req1_ready, 0);
      chk("fl_resp_valid", resp_valid, 0);
      chk("fl_stall", mul_stall, 2'b00);
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("fl_after_ready1", req1_ready, 1);
      chk("fl_after_valid", resp_valid, 0);
      tick();
      idle();
      @(negedge clk);
      chk("fl_after_valid2", resp_valid, 0);
      tick();
      wait_drain();

      // Asynchronous reset with both stages occupied.
      drv(0, {MUL, 32'd4, 32'd4, 4'd1, 32'd16});
      tick();
      drv(0, {MUL, 32'd5, 32'd5, 4'd2, 32'd25});
      tick();
      idle();
      resp_ready = 1'b0;
      @(negedge clk);
      chk("ar_valid_before", resp_valid, 1);
      chk("ar_stall_before", mul_stall, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid_async", resp_valid, 0);
      chk("ar_stall_async", mul_stall, 2'b00);
      tick();
      tick();
      rst_n = 1'b1;
      resp_ready = 1'b1;
      drv(0, {MUL, 32'd6, 32'd7, 4'd3, 32'd42});
      drv(1, {MUL, 32'd8, 32'd9, 4'd4, 32'd72});
      @(negedge clk);
      chk("ar_first_grant0", req0_ready, 1);
      chk("ar_first_grant1", req1_ready, 0);
      tick();
      idle();
      wait_drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mul_issue_arbiter.md
# mul_issue_arbiter

Shares the single 3-stage pipelined multiplier (booth partial products | wallace tree | final adder) between two integer issue pipes. Each pipe presents MUL/MULH/MULHU requests over a valid/ready handshake. The block round-robin arbitrates between them, drives the multiplier operands and `stall_i[1:0]`, and tracks a valid bit plus metadata for each multiplier stage. It returns the selected 32-bit result half to the originating pipe, with that pipe's tag, through a back-pressurable response port; a flush kills all in-flight work.

## Interface
- `TAG_W`, 4, width of the per-request tag returned unchanged with the result
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid_i`  in  1  pipe 0 request valid
- `req0_ready_o`  out  1  pipe 0 request accepted this cycle
- `req0_op_i`  in  2  2'b00 MUL (low 32), 2'b01 MULH (signed high), 2'b10 MULHU (unsigned high), 2'b11 reserved, treated as MUL
- `req0_x_i`, `req0_y_i`  in  32  operands
- `req0_tag_i`  in  TAG_W  pipe 0 tag
- `req1_*`  same set as pipe 0, for pipe 1
- `flush_i`  in  1  kill all in-flight operations; block all acceptance this cycle
- `mul_signed_o`  out  1  to multiplier `mul_signed_i`
- `mul_x_o`, `mul_y_o`  out  32  to multiplier `X_i`, `Y_i`
- `mul_stall_o`  out  2  to multiplier `stall_i`; [0] freezes stage 2 registers, [1] freezes stage 3 registers
- `mul_res_i`  in  64  from multiplier `res_o`, combinational off stage 3
- `resp_valid_o`  out  1  result valid
- `resp_ready_i`  in  1  consumer accepts result
- `resp_port_o`  out  1  originating pipe
- `resp_tag_o`  out  TAG_W  originating tag
- `resp_data_o`  out  32  result

## Operation
- State:
  - v2, v3 valid bits; per-stage metadata {port, op, tag} shadowing multiplier stages 2 and 3.
  - prio bit: pipe to favour on conflict.
- Stall generation:
  - `mul_stall_o[1]` = v3 & ~resp_ready_i (flush overrides, see below).
  - `mul_stall_o[0]` = `mul_stall_o[1]` & v2.
- Acceptance:
  - can_accept = ~`mul_stall_o[0]` & ~`flush_i`.
  - grant0 = `req0_valid_i` & (~`req1_valid_i` | prio==0) & can_accept.
  - grant1 = `req1_valid_i` & (~`req0_valid_i` | prio==1) & can_accept.
  - `reqN_ready_o` = grantN; at most one grant per cycle.
- Operand mux: grant1 selects pipe 1 operands/op; otherwise pipe 0 (including idle cycles). `mul_signed_o` = 1 for MUL/MULH, 0 for MULHU.
- Round-robin: on any grant, prio <= ~granted port. The prio bit is unchanged when idle.
- Stage advance:
  - When ~`mul_stall_o[0]`: v2 <= grant0|grant1, and meta2 loads.
  - When ~`mul_stall_o[1]`: v3 <= v2, meta3 <= meta2.
  - Garbage loaded into the multiplier with v=0 is harmless.
- Response:
  - `resp_valid_o` = v3 & ~`flush_i`.
  - `resp_data_o` = `mul_res_i[31:0]` for MUL/reserved, `mul_res_i[63:32]` for MULH/MULHU.
  - `resp_port_o` and `resp_tag_o` come from meta3.
- Flush:
  - Next edge clears v2, v3.
  - `mul_stall_o` forced to 2'b00 during flush.
  - No request is accepted in the flush cycle.
  - No response handshake occurs in the flush cycle.
- Reset: v2 = v3 = 0, prio = 0, metadata 0.

## Timing
- Request handshake in cycle N → `resp_valid_o` high in cycle N+2 (latency 2) if not back-pressured.
- Throughput: 1 operation/cycle sustained when `resp_ready_i`=1.
- Back-pressure:
  - `resp_ready_i`=0 with v3 freezes stage 3.
  - If v2 is also set, stage 2 freezes and both readies drop.
  - Maximum 2 operations in flight plus the one being offered; none is lost or duplicated.
- A request arriving while v3=1, v2=0 and `resp_ready_i`=0 is still accepted, because stage 2 is empty (bubble squeeze).
- `resp_valid_o` holds stable with unchanged data/tag until `resp_ready_i`, unless flushed.
- Readies depend combinationally on valids, `resp_ready_i` and `flush_i`. Valids must not depend on readies.
- Reset values: all readies 0, `resp_valid_o` 0, `mul_stall_o` 2'b00, `resp_port_o`/`resp_tag_o`/`resp_data_o` driven from zeroed meta3.
- Reset asserted mid-operation drops all in-flight work immediately and asynchronously.

## Test plan
- Pipe 0 MULHU x=0x00000003 y=0xFFFFFFFF tag=5 in cycle 0 → cycle 2 `resp_valid_o`=1, data=0x00000002, port=0, tag=5. The same operands as MULH → 0xFFFFFFFF; as MUL → 0xFFFFFFFD.
- Both pipes valid every cycle for 6 cycles, `resp_ready_i`=1 → grants alternate 0,1,0,1,0,1 (prio=0 after reset). Responses arrive in the same order, 2 cycles later, one per cycle.
- `resp_ready_i`=0 for 4 cycles with continuous pipe 0 requests → exactly 2 accepted, then `req0_ready_o`=0 and `mul_stall_o`=2'b11. Results come out in order, unchanged, after `resp_ready_i` rises.
- Bubble: accept A, idle one cycle, then hold `resp_ready_i`=0 while A is in stage 3 → B is accepted (`mul_stall_o`=2'b10). Both A and B are delivered correctly afterwards.
- `flush_i` pulse with 2 operations in flight and pipe 1 valid → no handshake in the flush cycle, `resp_valid_o`=0 the following cycles, and pipe 1 is accepted the cycle after the flush.
- Assert `rst_n` low with v2=v3=1 → `resp_valid_o` drops immediately. After release, the first simultaneous request is granted to pipe 0.
